// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types for the register-file access arbiter: host op codes, FSM states
// and the response payload carried through the holding register.
package regfile_access_arbiter_pkg;

    // Response fields are sized for the widest supported configuration; the
    // top zero-extends into them and slices back out to its own widths.
    localparam int unsigned RSP_DATA_MAX = 64;
    localparam int unsigned RSP_ADDR_MAX = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        ST_PROC,
        ST_DRAIN,
        ST_HOST_IDLE,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_WR,
        ST_DUMP_ADDR,
        ST_DUMP_CAP,
        ST_RSP,
        ST_RELEASE
    } state_e;

    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] data;
        logic [RSP_ADDR_MAX-1:0] addr;
        logic                    last;
        logic                    err;
    } rsp_t;

endpackage

// File: rtl/regfile_access_arbiter_rsp_holding_reg.sv
// Single-entry valid/ready holding register for host responses; payload stays
// stable from load until the handshake.
module rsp_holding_reg
    import regfile_access_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  rsp_t load_data,
    input  logic out_ready,
    output logic out_valid,
    output rsp_t out_data
);

    logic valid_q, valid_d;
    rsp_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/regfile_access_arbiter.sv
// Arbitrates the register-file ports between processor and test host, stalling
// the processor while the host runs read/write/dump commands.
module regfile_access_arbiter
    import regfile_access_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DUMP_FIRST = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  test_mode,
    input  logic                  p_we,
    input  logic [ADDR_WIDTH-1:0] p_wreg,
    input  logic [ADDR_WIDTH-1:0] p_rrA,
    input  logic [ADDR_WIDTH-1:0] p_rrB,
    input  logic [DATA_WIDTH-1:0] p_wdata,
    output logic                  proc_stall,
    output logic                  host_owns,
    input  logic                  h_cmd_valid,
    output logic                  h_cmd_ready,
    input  logic [1:0]            h_cmd_op,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_rsp_valid,
    input  logic                  h_rsp_ready,
    output logic [DATA_WIDTH-1:0] h_rsp_data,
    output logic [ADDR_WIDTH-1:0] h_rsp_addr,
    output logic                  h_rsp_last,
    output logic                  h_rsp_err,
    output logic                  r_we,
    output logic [ADDR_WIDTH-1:0] r_wreg,
    output logic [ADDR_WIDTH-1:0] r_rrA,
    output logic [ADDR_WIDTH-1:0] r_rrB,
    output logic [DATA_WIDTH-1:0] r_wdata,
    input  logic [DATA_WIDTH-1:0] r_rdataA
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(DUMP_FIRST);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  dump_q, dump_d;
    logic                  rsp_load;
    rsp_t                  rsp_in;
    rsp_t                  rsp_out;
    logic                  rsp_valid;
    logic                  unused_rsp_bits;

    // Next state, command capture and response loading.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        dump_d   = dump_q;
        rsp_load = 1'b0;
        rsp_in   = '0;
        case (state_q)
            ST_PROC:      if (test_mode) state_d = ST_DRAIN;
            ST_DRAIN:     state_d = ST_HOST_IDLE;
            ST_HOST_IDLE: begin
                if (h_cmd_valid) begin
                    idx_d   = h_addr;
                    wdata_d = h_wdata;
                    dump_d  = 1'b0;
                    case (op_e'(h_cmd_op))
                        OP_READ:  state_d = ST_RD_ADDR;
                        OP_WRITE: state_d = ST_WR;
                        OP_DUMP: begin
                            idx_d   = FIRST_IDX;
                            dump_d  = 1'b1;
                            state_d = ST_DUMP_ADDR;
                        end
                        default: begin
                            rsp_load    = 1'b1;
                            rsp_in.addr = RSP_ADDR_MAX'(h_addr);
                            rsp_in.last = 1'b1;
                            rsp_in.err  = 1'b1;
                            state_d     = ST_RSP;
                        end
                    endcase
                end else if (!test_mode) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RD_ADDR:   state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                rsp_load    = 1'b1;
                rsp_in.data = RSP_DATA_MAX'(r_rdataA);
                rsp_in.addr = RSP_ADDR_MAX'(idx_q);
                rsp_in.last = 1'b1;
                state_d     = ST_RSP;
            end
            ST_WR: begin
                rsp_load    = 1'b1;
                rsp_in.data = RSP_DATA_MAX'(wdata_q);
                rsp_in.addr = RSP_ADDR_MAX'(idx_q);
                rsp_in.last = 1'b1;
                state_d     = ST_RSP;
            end
            ST_DUMP_ADDR: state_d = ST_DUMP_CAP;
            ST_DUMP_CAP: begin
                rsp_load    = 1'b1;
                rsp_in.data = RSP_DATA_MAX'(r_rdataA);
                rsp_in.addr = RSP_ADDR_MAX'(idx_q);
                rsp_in.last = (idx_q == LAST_IDX);
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_valid && h_rsp_ready) begin
                    if (dump_q && (idx_q != LAST_IDX)) begin
                        idx_d   = idx_q + ADDR_WIDTH'(1);
                        state_d = ST_DUMP_ADDR;
                    end else begin
                        dump_d  = 1'b0;
                        state_d = ST_HOST_IDLE;
                    end
                end
            end
            ST_RELEASE:   state_d = ST_PROC;
            default:      state_d = ST_PROC;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_PROC;
            idx_q   <= '0;
            wdata_q <= '0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dump_q  <= dump_d;
        end
    end

    rsp_holding_reg u_rsp (
        .clock     (clock),
        .reset     (reset),
        .load      (rsp_load),
        .load_data (rsp_in),
        .out_ready (h_rsp_ready),
        .out_valid (rsp_valid),
        .out_data  (rsp_out)
    );

    assign h_rsp_valid     = rsp_valid;
    assign h_rsp_data      = rsp_out.data[DATA_WIDTH-1:0];
    assign h_rsp_addr      = rsp_out.addr[ADDR_WIDTH-1:0];
    assign h_rsp_last      = rsp_out.last;
    assign h_rsp_err       = rsp_out.err;
    assign unused_rsp_bits = ^rsp_out;

    assign proc_stall  = (state_q != ST_PROC);
    assign host_owns   = !(state_q inside {ST_PROC, ST_DRAIN, ST_RELEASE});
    assign h_cmd_ready = (state_q == ST_HOST_IDLE);

    // Regfile port mux: processor passthrough in PROC, host-driven otherwise; forced to 0 in reset.
    always_comb begin
        r_we    = 1'b0;
        r_wreg  = '0;
        r_rrA   = '0;
        r_rrB   = '0;
        r_wdata = '0;
        if (reset) begin
            if (state_q == ST_PROC) begin
                r_we    = p_we;
                r_wreg  = p_wreg;
                r_rrA   = p_rrA;
                r_rrB   = p_rrB;
                r_wdata = p_wdata;
            end else begin
                r_we    = (state_q == ST_WR);
                r_wreg  = idx_q;
                r_rrA   = idx_q;
                r_wdata = wdata_q;
            end
        end
    end

endmodule
